// File: rtl/mult_share_arb_pkg.sv
// mult_pkg: shared constants, ID width helper and default pipeline stage record
// Rev 1.0
`default_nettype none

package mult_pkg;

  localparam int DEF_N   = 4;
  localparam int DEF_L1  = 8;
  localparam int DEF_L2  = 8;
  localparam int DEF_LAT = 2;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_w(DEF_N);

  typedef struct packed {
    logic                       valid;
    logic [DEF_ID_W-1:0]        id;
    logic [DEF_L1+DEF_L2-1:0]   prod;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: request/response bundle between clients and the shared multiplier
// Rev 1.0
`default_nettype none

interface mult_share_arb_if
  import mult_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int L1 = DEF_L1,
  parameter int L2 = DEF_L2
) ();

  localparam int ID_W = id_w(N);

  logic                hold;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*L1-1:0]     req_in1;
  logic [N*L2-1:0]     req_in2;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [L1+L2-1:0]    rsp_out;
  logic                busy;

  modport master (
    output hold, req_valid, req_in1, req_in2,
    input  req_ready, rsp_valid, rsp_id, rsp_out, busy
  );

  modport slave (
    input  hold, req_valid, req_in1, req_in2,
    output req_ready, rsp_valid, rsp_id, rsp_out, busy
  );

endinterface

`default_nettype wire

// File: rtl/mult_share_arb_arbiter.sv
// rr_arbiter: N-way round-robin one-hot grant, searching from last+1 upward with wrap
// Rev 1.0
`default_nettype none

module rr_arbiter
  import mult_pkg::*;
#(
  parameter int  N    = DEF_N,
  localparam int ID_W = id_w(N)
) (
  input  wire logic [N-1:0]    req,
  input  wire logic            en,
  input  wire logic [ID_W-1:0] last,
  output logic      [N-1:0]    grant
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = ID_W'((int'(last) + k) % N);
      if (en && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one LAT-stage unsigned multiplier among N requesters
// Rev 1.0
`default_nettype none

module mult_share_arb
  import mult_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int L1  = DEF_L1,
  parameter int L2  = DEF_L2,
  parameter int LAT = DEF_LAT
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mult_share_arb_if.slave   bus
);

  localparam int ID_W = id_w(N);
  localparam int P_W  = L1 + L2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  prod;
  } pipe_t;

  logic [N-1:0]    w_grant;
  logic            w_xfer;
  logic [ID_W-1:0] w_gidx;
  logic [L1-1:0]   w_in1;
  logic [L2-1:0]   w_in2;
  logic [P_W-1:0]  w_prod;
  logic [LAT-1:0]  w_stage_vld;
  logic [ID_W-1:0] r_last;
  pipe_t           r_pipe [LAT];

  rr_arbiter #(.N(N)) u_arb (
    .req   (bus.req_valid),
    .en    (~bus.hold),
    .last  (r_last),
    .grant (w_grant)
  );

  assign bus.req_ready = w_grant;
  assign w_xfer        = |(bus.req_valid & w_grant);

  // One-hot grant selects the operand pair that feeds the shared multiplier
  always_comb begin
    w_gidx = '0;
    w_in1  = '0;
    w_in2  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gidx = ID_W'(i);
        w_in1  = bus.req_in1[i*L1 +: L1];
        w_in2  = bus.req_in2[i*L2 +: L2];
      end
    end
  end

  assign w_prod = P_W'(w_in1) * P_W'(w_in2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= ID_W'(N - 1);
    end else if (w_xfer) begin
      r_last <= w_gidx;
    end
  end

  // Head stage keeps its payload when idle so the output holds the last valid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_xfer;
      if (w_xfer) begin
        r_pipe[0].id   <= w_gidx;
        r_pipe[0].prod <= w_prod;
      end
      for (int k = 1; k < LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  always_comb begin
    w_stage_vld = '0;
    for (int k = 0; k < LAT; k++) begin
      w_stage_vld[k] = r_pipe[k].valid;
    end
  end

  assign bus.rsp_valid = r_pipe[LAT-1].valid;
  assign bus.rsp_id    = r_pipe[LAT-1].id;
  assign bus.rsp_out   = r_pipe[LAT-1].prod;
  assign bus.busy      = |w_stage_vld;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed and randomized checks of mult_share_arb against a queue-based model
// Rev 1.0
`default_nettype none

module tb_mult_share_arb;
  import mult_pkg::*;

  localparam int N    = 4;
  localparam int L1   = 8;
  localparam int L2   = 8;
  localparam int LAT  = 2;
  localparam int ID_W = id_w(N);
  localparam int P_W  = L1 + L2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_arb_if #(.N(N), .L1(L1), .L2(L2)) bus ();

  mult_share_arb #(.N(N), .L1(L1), .L2(L2), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int due;
    int id;
    int prod;
  } exp_t;

  exp_t q[$];
  int   m_last;
  int   cyc;
  int   total = 0;
  int   bad   = 0;

  logic [N-1:0] exp_g;
  logic         ev, eb;
  int           eid, eout;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (!bus.hold) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (bus.req_valid[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    bus.req_in1[i*L1 +: L1] = L1'(a);
    bus.req_in2[i*L2 +: L2] = L2'(b);
  endtask

  // Advances one clock, records any transfer in the model and returns what should be visible next
  task automatic clk_cycle(output logic o_ev, output int o_eid, output int o_eout, output logic o_eb);
    logic [N-1:0] g;
    g = model_grant();
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        q.push_back('{cyc + LAT, i,
                      int'(bus.req_in1[i*L1 +: L1]) * int'(bus.req_in2[i*L2 +: L2])});
        m_last = i;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    o_eb   = (q.size() > 0);
    o_ev   = 1'b0;
    o_eid  = 0;
    o_eout = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      o_ev   = 1'b1;
      o_eid  = q[0].id;
      o_eout = q[0].prod;
      void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    q.delete();
    m_last = N - 1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_id !== '0 ||
        bus.rsp_out !== '0 || bus.req_ready !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%b busy=%b id=%0d out=%0d rdy=%b, want all zero",
               bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, bus.req_ready);
    end
    rst_n  = 1'b1;
    q.delete();
    m_last = N - 1;
  endtask

  task automatic test_single();
    for (int c = 1; c <= LAT + 1; c++) begin
      bus.req_valid = (c == 1) ? 4'b0100 : 4'b0000;
      set_op(2, 200, 100);
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g || (c == 1 && bus.req_ready !== 4'b0100)) begin
        bad++;
        $display("FAIL single_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL single_rsp c=%0d: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
      if (c == LAT) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(2) || bus.rsp_out !== P_W'(20000)) begin
          bad++;
          $display("FAIL single_product: got v=%b id=%0d out=%0d want v=1 id=2 out=20000",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_out);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    for (int c = 0; c < 12 + LAT + 1; c++) begin
      bus.req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g || (c < 12 && bus.req_ready !== N'(1 << (c % N)))) begin
        bad++;
        $display("FAIL rr_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL rr_rsp c=%0d: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
    end
  endtask

  task automatic test_extremes();
    for (int c = 1; c <= LAT + 2; c++) begin
      bus.req_valid = (c <= 2) ? 4'b0001 : 4'b0000;
      if (c == 1) set_op(0, 255, 255);
      else        set_op(0, 0, 255);
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g) begin
        bad++;
        $display("FAIL ext_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      if (c == LAT || c == LAT + 1) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== '0 ||
            bus.rsp_out !== ((c == LAT) ? P_W'(16'hFE01) : P_W'(0))) begin
          bad++;
          $display("FAIL ext_product c=%0d: got v=%b id=%0d out=%0d want v=1 id=0 out=%0d",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_out, (c == LAT) ? 65025 : 0);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_op(1, 3, 4);
    set_op(3, 5, 6);
    for (int c = 0; c < 10 + LAT; c++) begin
      bus.hold      = (c >= 1 && c <= 4);
      bus.req_valid = (c == 0) ? 4'b0010 : (c <= 5) ? 4'b1010 : (c == 6) ? 4'b0010 : 4'b0000;
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g ||
          (c >= 1 && c <= 4 && bus.req_ready !== 4'b0000) ||
          (c == 5 && bus.req_ready !== 4'b1000) ||
          (c == 6 && bus.req_ready !== 4'b0010)) begin
        bad++;
        $display("FAIL hold_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL hold_rsp c=%0d: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 7, i + 2);
    bus.req_valid = 4'b1111;
    repeat (2) clk_cycle(ev, eid, eout, eb);
    bus.req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got v=%b busy=%b want v=0 busy=0", bus.rsp_valid, bus.busy);
    end
    q.delete();
    m_last = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      bus.req_valid = (c == LAT + 2) ? 4'b1111 : 4'b0000;
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g || (c == LAT + 2 && bus.req_ready !== 4'b0001)) begin
        bad++;
        $display("FAIL midreset_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb) begin
        bad++;
        $display("FAIL midreset_stale c=%0d: got v=%b b=%b want v=%b b=%b",
                 c, bus.rsp_valid, bus.busy, ev, eb);
      end
    end
    bus.req_valid = '0;
    repeat (LAT + 1) clk_cycle(ev, eid, eout, eb);
  endtask

  task automatic test_idle_retain();
    int busy_cnt;
    do_reset();
    busy_cnt = 0;
    set_op(1, 9, 9);
    set_op(2, 11, 12);
    for (int c = 0; c < LAT + 2; c++) begin
      bus.req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g) begin
        bad++;
        $display("FAIL idle_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      clk_cycle(ev, eid, eout, eb);
      if (bus.busy === 1'b1) busy_cnt++;
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL idle_rsp c=%0d: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
    end
    total++;
    if (busy_cnt != LAT) begin
      bad++;
      $display("FAIL idle_busy_len: got %0d cycles want %0d", busy_cnt, LAT);
    end
    bus.req_valid = 4'b0110;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL idle_last_kept: got %b want 0100", bus.req_ready);
    end
    clk_cycle(ev, eid, eout, eb);
    bus.req_valid = '0;
    repeat (LAT + 2) clk_cycle(ev, eid, eout, eb);
  endtask

  task automatic test_random();
    int waits [N];
    do_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      exp_g = model_grant();
      total++;
      if (bus.req_ready !== exp_g) begin
        bad++;
        $display("FAIL rnd_grant c=%0d: got %b want %b", c, bus.req_ready, exp_g);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          total++;
          if (waits[i] > N - 1) begin
            bad++;
            $display("FAIL rnd_fairness req=%0d: waited %0d grants, limit %0d", i, waits[i], N - 1);
          end
          waits[i] = 0;
        end else if (bus.req_valid[i] && (|bus.req_ready)) begin
          waits[i]++;
        end
      end
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL rnd_rsp c=%0d: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 c, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
      // Requesters only change operands once idle or just granted
      for (int i = 0; i < N; i++) begin
        if (exp_g[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 60);
          if ($urandom_range(0, 7) == 0) set_op(i, 255, 255);
          else set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
      bus.hold = ($urandom_range(0, 9) == 0);
    end
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    repeat (LAT + 1) begin
      clk_cycle(ev, eid, eout, eb);
      total++;
      if (bus.rsp_valid !== ev || bus.busy !== eb ||
          (ev && (bus.rsp_id !== ID_W'(eid) || bus.rsp_out !== P_W'(eout)))) begin
        bad++;
        $display("FAIL rnd_drain: got v=%b b=%b id=%0d out=%0d want v=%b b=%b id=%0d out=%0d",
                 bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_out, ev, eb, eid, eout);
      end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_hold();
    test_reset_midflight();
    test_idle_retain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin scheduler that shares one pipelined unsigned multiplier among N requesters. Each requester presents two operands with a valid/ready handshake. The block grants at most one requester per cycle, pushes the operands through an LAT-stage multiply pipeline, and returns the full-width product tagged with the requester index. It sits between the compute clients and the multiplier datapath, so one multiplier can serve several channels without duplication.

## Interface
- N, 4: number of requesters (2..16).
- L1, 8: width of operand 1.
- L2, 8: width of operand 2.
- LAT, 2: multiply pipeline depth in cycles (>=1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- hold  in  1  when 1, no new grants are issued; the pipeline keeps draining.
- req_valid  in  N  bit i: requester i has an operand pair.
- req_ready  out  N  one-hot or zero: grant to requester i this cycle.
- req_in1  in  N*L1  operand 1, requester i at bits [i*L1 +: L1].
- req_in2  in  N*L2  operand 2, requester i at bits [i*L2 +: L2].
- rsp_valid  out  1  product valid.
- rsp_id  out  ID_W  requester index of the product; ID_W = max(1, clog2(N)).
- rsp_out  out  L1+L2  unsigned product in1*in2.
- busy  out  1  1 while any pipeline stage holds a valid entry.

## Operation
- Arbitration is combinational. `req_ready` is the one-hot grant, derived from `req_valid`, `hold` and the priority pointer `last`.
- Search order is last+1, last+2, … up to last, wrapping modulo N. The first requester with valid=1 is granted.
- `hold`=1 or no valid request: `req_ready`=0.
- A transfer occurs when `req_valid[i] & req_ready[i]`. On a transfer, `last` <= i. With no transfer, `last` is unchanged.
- Requesters must hold their valid and operands stable until granted. The block never drops a granted transfer.
- Product: the full-width unsigned product `in1*in2` (L1+L2 bits). There is no truncation or overflow; the maximum is (2^L1-1)*(2^L2-1).
- Pipeline: stage 0 captures {valid, id, product} on a transfer. Stages 1..LAT-1 shift unconditionally every cycle.
- There is no response backpressure. The consumer must accept every `rsp_valid` pulse.
- `busy` = OR of all stage valid bits.
- Reset (rst_n=0, any time, including mid-operation):
  - `last` <= N-1, so requester 0 has first priority after reset.
  - All stage valids <= 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_out` = 0, `busy` = 0.
  - In-flight products are discarded.
- Data registers also reset to 0.
- `rsp_id` and `rsp_out` are held from the last valid entry when `rsp_valid`=0. The verifier checks them only when `rsp_valid`=1.

## Timing
- `req_ready` is valid in the same cycle as `req_valid` (combinational path).
- Latency: a transfer at edge k produces `rsp_valid`=1 in the cycle after edge k+LAT-1. That is, LAT cycles from the grant cycle to the response cycle.
- Throughput: one product per cycle. Back-to-back grants produce back-to-back responses in grant order.
- Simultaneous requests: exactly one is granted per cycle. The others wait, and each waits at most N-1 grants (fairness bound).
- `hold` rising: it takes effect in the same cycle, so no grant is issued in that cycle. Entries already in the pipeline still emerge on schedule.
- `busy` falls in the cycle after the last valid entry leaves stage LAT-1.

## Structure
- Package `mult_pkg`:
  - `clog2`-based `ID_W` function.
  - Default L1/L2/N/LAT constants.
  - Typedef for the pipeline stage record {valid, id, product}.
- Sub-module `rr_arbiter` (N-way round-robin, parameter N): inputs `req`, `en`, `last`; output one-hot `grant`. Reused elsewhere.
- The multiply is inferred inline in the top module (`in1*in2` of the granted mux output). There is no separate multiplier instance.

## Test plan
- Reset, then only req_valid[2]=1 with in1=200, in2=100 → req_ready=0b0100 in the same cycle; after LAT cycles, rsp_valid=1, rsp_id=2, rsp_out=20000.
- All four requesters valid continuously (in1=i+1, in2=10) → grants in order 0,1,2,3,0,…; responses in that order with rsp_out=10,20,30,40; rsp_valid held high every cycle.
- Extreme operands in1=255, in2=255 → rsp_out=65025 (0xFE01); in1=0, in2=255 → 0.
- hold=1 while requesters 1 and 3 are valid → req_ready=0 throughout; when hold falls with last=1, requester 3 is granted first, then 1.
- Assert rst_n=0 while 2 entries are in flight → rsp_valid=0 and busy=0 immediately; no stale response appears after release; the first grant after reset goes to requester 0.
- Grant requester 1, then leave all valids low → busy is high for LAT cycles then low; last=1 is retained, so with requesters 1 and 2 then both valid, requester 2 is granted first.
